// File: rtl/vga_plot_arbiter_if.sv
// Pixel-request bus shared by the three requesters and the vga_adapter write side.
// The arbiter takes the slave view; the requester side (or a bench) takes the master view.
interface vga_plot_arbiter_if #(
   parameter int XSZ   = 8,
   parameter int YSZ   = 7,
   parameter int COLSZ = 3
);
   logic [2:0]         req;
   logic [2:0]         pix_valid;
   logic [2:0]         pix_last;
   logic [3*XSZ-1:0]   x_in;
   logic [3*YSZ-1:0]   y_in;
   logic [3*COLSZ-1:0] col_in;

   logic [2:0]         gnt;
   logic               busy;
   logic [XSZ-1:0]     x_out;
   logic [YSZ-1:0]     y_out;
   logic [COLSZ-1:0]   col_out;
   logic               plot_en;
   logic               timeout_err;

   modport master (
      output req, pix_valid, pix_last, x_in, y_in, col_in,
      input  gnt, busy, x_out, y_out, col_out, plot_en, timeout_err
   );

   modport slave (
      input  req, pix_valid, pix_last, x_in, y_in, col_in,
      output gnt, busy, x_out, y_out, col_out, plot_en, timeout_err
   );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter for the single vga_adapter write port, with
// on-screen clipping and a per-grant cycle watchdog. All outputs are registered.
module vga_plot_arbiter #(
   parameter int XSZ     = 8,
   parameter int YSZ     = 7,
   parameter int COLSZ   = 3,
   parameter int XMAX    = 160,
   parameter int YMAX    = 120,
   parameter int MAX_CYC = 19200,
   parameter int CW      = 15
) (
   input logic               clk,
   input logic               resetn,
   vga_plot_arbiter_if.slave bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   localparam logic [XSZ:0]  X_LIM    = (XSZ+1)'(XMAX);
   localparam logic [YSZ:0]  Y_LIM    = (YSZ+1)'(YMAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYC - 1);

   logic [0:0]       state;
   logic [1:0]       ptr;
   logic [1:0]       owner;
   logic [1:0]       pick;
   logic [CW-1:0]    cnt;

   logic [XSZ-1:0]   own_x;
   logic [YSZ-1:0]   own_y;
   logic [COLSZ-1:0] own_col;
   logic             own_valid;
   logic             own_last;
   logic             own_req;

   logic             in_range;
   logic             plot_now;
   logic             normal_end;
   logic             forced_end;
   logic             burst_end;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // First requesting index at or after ptr, wrapping mod 3; only used when req != 0.
   always_comb begin
      pick = 2'd0;
      case (ptr)
         2'd1:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
         2'd2:    pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
         default: pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      own_x     = bus.x_in[0 +: XSZ];
      own_y     = bus.y_in[0 +: YSZ];
      own_col   = bus.col_in[0 +: COLSZ];
      own_valid = bus.pix_valid[0];
      own_last  = bus.pix_last[0];
      own_req   = bus.req[0];
      case (owner)
         2'd1: begin
            own_x     = bus.x_in[XSZ +: XSZ];
            own_y     = bus.y_in[YSZ +: YSZ];
            own_col   = bus.col_in[COLSZ +: COLSZ];
            own_valid = bus.pix_valid[1];
            own_last  = bus.pix_last[1];
            own_req   = bus.req[1];
         end
         2'd2: begin
            own_x     = bus.x_in[2*XSZ +: XSZ];
            own_y     = bus.y_in[2*YSZ +: YSZ];
            own_col   = bus.col_in[2*COLSZ +: COLSZ];
            own_valid = bus.pix_valid[2];
            own_last  = bus.pix_last[2];
            own_req   = bus.req[2];
         end
         default: ;
      endcase
   end

   // A normal end in the expiry cycle wins, so timeout_err only flags true overruns.
   assign in_range   = ({1'b0, own_x} < X_LIM) && ({1'b0, own_y} < Y_LIM);
   assign plot_now   = own_valid && in_range;
   assign normal_end = (own_valid && own_last) || !own_req;
   assign forced_end = !normal_end && (cnt == CNT_LAST);
   assign burst_end  = normal_end || forced_end;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         ptr             <= 2'd0;
         owner           <= 2'd0;
         cnt             <= '0;
         bus.gnt         <= 3'b000;
         bus.busy        <= 1'b0;
         bus.x_out       <= '0;
         bus.y_out       <= '0;
         bus.col_out     <= '0;
         bus.plot_en     <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.plot_en     <= 1'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req != 3'b000) begin
                  state    <= OWN;
                  owner    <= pick;
                  cnt      <= '0;
                  bus.gnt  <= 3'b001 << pick;
                  bus.busy <= 1'b1;
               end
            end
            OWN: begin
               cnt <= cnt + CW'(1);
               if (plot_now) begin
                  bus.plot_en <= 1'b1;
                  bus.x_out   <= own_x;
                  bus.y_out   <= own_y;
                  bus.col_out <= own_col;
               end
               if (burst_end) begin
                  state           <= IDLE;
                  ptr             <= next_idx(owner);
                  bus.gnt         <= 3'b000;
                  bus.busy        <= 1'b0;
                  bus.timeout_err <= forced_end;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_vga_plot_arbiter;

   localparam int XSZ   = 8;
   localparam int YSZ   = 7;
   localparam int COLSZ = 3;
   localparam int MAXC  = 8;

   logic clk = 1'b0;
   logic resetn;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   vga_plot_arbiter_if #(.XSZ(XSZ), .YSZ(YSZ), .COLSZ(COLSZ)) bus ();

   vga_plot_arbiter #(
      .XSZ(XSZ), .YSZ(YSZ), .COLSZ(COLSZ),
      .XMAX(160), .YMAX(120), .MAX_CYC(MAXC), .CW(4)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int               m_owner;
   int               m_ptr;
   int               m_cnt;
   logic [2:0]       e_gnt;
   logic             e_busy;
   logic             e_plot;
   logic             e_to;
   logic [XSZ-1:0]   e_x;
   logic [YSZ-1:0]   e_y;
   logic [COLSZ-1:0] e_col;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      e_gnt   = 3'b000;
      e_busy  = 1'b0;
      e_plot  = 1'b0;
      e_to    = 1'b0;
      e_x     = '0;
      e_y     = '0;
      e_col   = '0;
   endtask

   // One clock edge of the arbitration rules, using the inputs seen at that edge.
   task automatic model_step();
      int g;
      int x;
      int y;
      bit found;
      bit v;
      bit normal;
      bit forced;
      e_plot = 1'b0;
      e_to   = 1'b0;
      if (m_owner < 0) begin
         if (bus.req != 3'b000) begin
            found = 1'b0;
            for (int k = 0; k < 3; k++) begin
               g = (m_ptr + k) % 3;
               if (!found && bus.req[g]) begin
                  found   = 1'b1;
                  m_owner = g;
               end
            end
            e_gnt  = 3'(1 << m_owner);
            e_busy = 1'b1;
            m_cnt  = 0;
         end
      end else begin
         g = m_owner;
         v = bus.pix_valid[g];
         x = int'(bus.x_in[g*XSZ +: XSZ]);
         y = int'(bus.y_in[g*YSZ +: YSZ]);
         if (v && x < 160 && y < 120) begin
            e_plot = 1'b1;
            e_x    = XSZ'(x);
            e_y    = YSZ'(y);
            e_col  = bus.col_in[g*COLSZ +: COLSZ];
         end
         normal = (v && bus.pix_last[g]) || !bus.req[g];
         forced = !normal && (m_cnt == MAXC - 1);
         m_cnt++;
         if (normal || forced) begin
            e_to    = forced;
            e_gnt   = 3'b000;
            e_busy  = 1'b0;
            m_ptr   = (g + 1) % 3;
            m_owner = -1;
         end
      end
   endtask

   always @(negedge resetn) model_reset();

   always @(posedge clk) begin
      if (!resetn) model_reset();
      else         model_step();
      #2;
      checkOutput("gnt",         bus.gnt,         e_gnt);
      checkOutput("busy",        bus.busy,        e_busy);
      checkOutput("plot_en",     bus.plot_en,     e_plot);
      checkOutput("timeout_err", bus.timeout_err, e_to);
      checkOutput("x_out",       bus.x_out,       e_x);
      checkOutput("y_out",       bus.y_out,       e_y);
      checkOutput("col_out",     bus.col_out,     e_col);
   end

   task automatic check_zero(input string tag);
      checkOutput({tag, "_gnt"},     bus.gnt,         0);
      checkOutput({tag, "_busy"},    bus.busy,        0);
      checkOutput({tag, "_plot"},    bus.plot_en,     0);
      checkOutput({tag, "_timeout"}, bus.timeout_err, 0);
      checkOutput({tag, "_x"},       bus.x_out,       0);
      checkOutput({tag, "_y"},       bus.y_out,       0);
      checkOutput({tag, "_col"},     bus.col_out,     0);
   endtask

   task automatic set_pix(input int i, input int x, input int y, input int c);
      bus.x_in[i*XSZ +: XSZ]       = XSZ'(x);
      bus.y_in[i*YSZ +: YSZ]       = YSZ'(y);
      bus.col_in[i*COLSZ +: COLSZ] = COLSZ'(c);
   endtask

   // Drive one cycle of requester inputs; returns at the following falling edge.
   task automatic applyStimulus(input logic [2:0] r, input logic [2:0] v, input logic [2:0] l);
      bus.req       = r;
      bus.pix_valid = v;
      bus.pix_last  = l;
      @(negedge clk);
   endtask

   task automatic reset_dut(input string tag);
      bus.req       = 3'($urandom);
      bus.pix_valid = 3'($urandom);
      bus.pix_last  = 3'($urandom);
      bus.x_in      = (3*XSZ)'($urandom);
      bus.y_in      = (3*YSZ)'($urandom);
      bus.col_in    = (3*COLSZ)'($urandom);
      resetn        = 1'b0;
      #1;
      check_zero(tag);
      @(negedge clk);
      bus.req       = 3'b000;
      bus.pix_valid = 3'b000;
      bus.pix_last  = 3'b000;
      resetn        = 1'b1;
   endtask

   logic [2:0] order [4];

   initial begin
      resetn        = 1'b0;
      bus.req       = 3'b000;
      bus.pix_valid = 3'b000;
      bus.pix_last  = 3'b000;
      bus.x_in      = '0;
      bus.y_in      = '0;
      bus.col_in    = '0;
      model_reset();
      @(negedge clk);

      // Reset and idle with no requests
      reset_dut("t1");
      for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b000, 3'b000);
      check_zero("t1_idle");

      // Single four-pixel burst from requester 1
      applyStimulus(3'b010, 3'b000, 3'b000);
      checkOutput("t2_gnt", bus.gnt, 3'b010);
      for (int p = 0; p < 4; p++) begin
         set_pix(1, 10 + p, 20, 5);
         applyStimulus(3'b010, 3'b010, (p == 3) ? 3'b010 : 3'b000);
         checkOutput("t2_plot", bus.plot_en, 1);
         checkOutput("t2_x",    bus.x_out,   10 + p);
         checkOutput("t2_y",    bus.y_out,   20);
         checkOutput("t2_col",  bus.col_out, 5);
      end
      checkOutput("t2_release", bus.gnt, 3'b000);
      applyStimulus(3'b111, 3'b000, 3'b000);
      checkOutput("t2_next_gnt", bus.gnt, 3'b100);
      applyStimulus(3'b111, 3'b100, 3'b100);

      // Contention with all three requesting
      reset_dut("t3");
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(3'b111, 3'b000, 3'b000);
         checkOutput("t3_gnt", bus.gnt, order[k]);
         applyStimulus(3'b111, order[k], order[k]);
         checkOutput("t3_idle_gap", bus.gnt, 3'b000);
      end

      // Clipping at the screen edge
      reset_dut("t4");
      applyStimulus(3'b001, 3'b000, 3'b000);
      checkOutput("t4_gnt", bus.gnt, 3'b001);
      set_pix(0, 160, 5, 3);
      applyStimulus(3'b001, 3'b001, 3'b000);
      checkOutput("t4_clip_plot", bus.plot_en, 0);
      checkOutput("t4_clip_x",    bus.x_out,   0);
      set_pix(0, 159, 119, 6);
      applyStimulus(3'b001, 3'b001, 3'b001);
      checkOutput("t4_edge_plot", bus.plot_en, 1);
      checkOutput("t4_edge_x",    bus.x_out,   159);
      checkOutput("t4_edge_y",    bus.y_out,   119);
      checkOutput("t4_edge_col",  bus.col_out, 6);

      // Watchdog expiry, then a normal end exactly at expiry
      reset_dut("t5");
      set_pix(0, 1, 1, 1);
      set_pix(2, 2, 2, 2);
      applyStimulus(3'b101, 3'b000, 3'b000);
      checkOutput("t5_gnt", bus.gnt, 3'b001);
      for (int c = 1; c <= MAXC; c++) begin
         applyStimulus(3'b101, 3'b001, 3'b000);
         if (c < MAXC) begin
            checkOutput("t5_held",    bus.gnt,         3'b001);
            checkOutput("t5_no_tout", bus.timeout_err, 0);
         end else begin
            checkOutput("t5_forced_rel", bus.gnt,         3'b000);
            checkOutput("t5_tout",       bus.timeout_err, 1);
         end
      end
      applyStimulus(3'b101, 3'b000, 3'b000);
      checkOutput("t5_next_gnt",   bus.gnt,         3'b100);
      checkOutput("t5_tout_pulse", bus.timeout_err, 0);
      applyStimulus(3'b101, 3'b100, 3'b100);
      applyStimulus(3'b001, 3'b000, 3'b000);
      checkOutput("t5b_gnt", bus.gnt, 3'b001);
      for (int c = 1; c <= MAXC; c++)
         applyStimulus(3'b001, 3'b001, (c == MAXC) ? 3'b001 : 3'b000);
      checkOutput("t5b_rel",     bus.gnt,         3'b000);
      checkOutput("t5b_no_tout", bus.timeout_err, 0);

      // Reset in the middle of a burst
      reset_dut("t6_pre");
      applyStimulus(3'b001, 3'b000, 3'b000);
      set_pix(0, 30, 30, 2);
      applyStimulus(3'b001, 3'b001, 3'b000);
      checkOutput("t6_first_plot", bus.plot_en, 1);
      set_pix(0, 31, 30, 2);
      bus.pix_valid = 3'b001;
      #2;
      resetn = 1'b0;
      #1;
      check_zero("t6_async");
      @(negedge clk);
      resetn = 1'b1;
      applyStimulus(3'b111, 3'b000, 3'b000);
      checkOutput("t6_restart_gnt", bus.gnt, 3'b001);

      // Random traffic against the model
      reset_dut("rnd");
      for (int n = 0; n < 2000; n++) begin
         logic [2:0] r, v, l;
         for (int i = 0; i < 3; i++) begin
            r[i] = ($urandom_range(0, 9) < 7);
            v[i] = ($urandom_range(0, 9) < 5);
            l[i] = ($urandom_range(0, 9) < 2);
            set_pix(i, int'($urandom_range(140, 175)), int'($urandom_range(100, 127)),
                    int'($urandom_range(0, 7)));
         end
         applyStimulus(r, v, l);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
